// File: rtl/sysbus_mem_responder.sv
// System-bus responder: word-addressed RAM at BASE_ADDR with programmable wait states,
// byte-strobe writes and misaligned/unmapped address error reporting.
module sysbus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) * 33'd4;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] acc_addr;
  logic        acc_we;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic [31:0] off;
  logic        acc_err;
  logic [AW-1:0] idx;
  logic        fire;

  assign req_ready  = (state == IDLE) && rst_n;
  assign resp_valid = (state == RESP);

  // With zero wait states the access happens on the accept edge, so it must use the
  // live request rather than the latched copy.
  always_comb begin
    acc_addr  = lat_addr;
    acc_we    = lat_we;
    acc_wdata = lat_wdata;
    acc_wstrb = lat_wstrb;
    if (state == IDLE) begin
      acc_addr  = req_addr;
      acc_we    = req_we;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end
    off     = acc_addr - BASE_ADDR;
    acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
    idx     = off[AW+1:2];
    if (ZERO_WAIT) fire = rst_n && (state == IDLE) && req_valid;
    else           fire = rst_n && (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (fire && acc_we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            if (ZERO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        resp_rdata <= (!acc_we && !acc_err) ? mem[idx] : '0;
        resp_error <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench: directed protocol scenarios plus random traffic scored against a
// word-array memory model derived from the address decode and strobe rules.
module tb_sysbus_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [DEPTH];

  sysbus_mem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one access: returns expected rdata/error and updates the model.
  task automatic model_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic [31:0] erd, output logic eerr);
    logic [31:0] offset;
    offset = addr - BASE;
    erd  = 32'h0;
    eerr = 1'b0;
    if ((addr % 4) != 0 || offset >= DEPTH * 4) begin
      eerr = 1'b1;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) model[offset / 4][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      erd = model[offset / 4];
    end
  endtask

  task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int hold, input string tag,
                     output logic [31:0] obs);
    logic [31:0] erd;
    logic        eerr;
    int          n;
    int          lat;
    model_access(addr, we, wdata, wstrb, erd, eerr);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    req_wstrb = wstrb;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WAITC));
    check({tag, " rdata"}, resp_rdata, erd);
    check({tag, " error"}, 32'(resp_error), 32'(eerr));
    obs = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold rdata"}, resp_rdata, erd);
      check({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, " resp done"}, 32'(resp_valid), 32'd0);
    check({tag, " idle ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] a;
    int n;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_addr = BASE;
    req_we = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    resp_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst rdata", resp_rdata, 32'h0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst release ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++)
      txn(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 0, "fill", obs);

    txn(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, "wr10", obs);
    txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, "rd10", obs);
    check("rd10 const", obs, 32'hDEAD_BEEF);

    txn(32'h8000_0040, 1'b1, 32'h1122_3344, 4'hF, 0, "strb full", obs);
    txn(32'h8000_0040, 1'b1, 32'hAABB_CCDD, 4'b0101, 0, "strb part", obs);
    txn(32'h8000_0040, 1'b0, 32'h0, 4'h0, 0, "strb rd", obs);
    check("strb const", obs, 32'h11BB_33DD);
    txn(32'h8000_0044, 1'b1, 32'h5555_5555, 4'h0, 0, "strb none", obs);
    txn(32'h8000_0044, 1'b0, 32'h0, 4'h0, 0, "strb none rd", obs);

    txn(32'h8000_0002, 1'b0, 32'h0, 4'h0, 0, "err misalign", obs);
    txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, "err below", obs);
    txn(BASE + DEPTH * 4, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, "err above", obs);
    txn(BASE + DEPTH * 4 - 1, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, "err top misalign", obs);
    txn(BASE, 1'b0, 32'h0, 4'h0, 0, "word0", obs);
    txn(BASE + (DEPTH - 1) * 4, 1'b0, 32'h0, 4'h0, 0, "word last", obs);

    txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 10, "backpressure", obs);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0020;
    req_we    = 1'b1;
    req_wdata = ~model[8];
    req_wstrb = 4'hF;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, "abort rd", obs);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        1:       a = BASE - 32'(4 * $urandom_range(1, 8));
        2:       a = BASE + DEPTH * 4 + 32'(4 * $urandom_range(0, 8));
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), "rand", obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
